// File: rtl/hermes_builder_if.sv
// Hermes packet builder bus: descriptor handshake, payload stream and tx/eop/credit link.
// master: the builder side. slave: the environment feeding descriptors/payload and
// receiving flits.
interface hermes_builder_if #(
    parameter int unsigned FLIT_SIZE = 32,
    parameter int unsigned LEN_W     = 16
);
    // Descriptor handshake
    logic                 desc_valid_i;
    logic                 desc_ready_o;
    logic [15:0]          desc_target_i;
    logic [31:0]          desc_service_i;
    logic [15:0]          desc_task_i;
    logic [15:0]          desc_cons_i;
    logic [LEN_W-1:0]     desc_len_i;

    // Payload stream
    logic                 pld_valid_i;
    logic                 pld_ready_o;
    logic [FLIT_SIZE-1:0] pld_data_i;

    // Hermes link
    logic                 tx_o;
    logic                 eop_o;
    logic [FLIT_SIZE-1:0] data_o;
    logic                 credit_i;

    modport master (
        input  desc_valid_i, desc_target_i, desc_service_i, desc_task_i, desc_cons_i,
        input  desc_len_i, pld_valid_i, pld_data_i, credit_i,
        output desc_ready_o, pld_ready_o, tx_o, eop_o, data_o
    );

    modport slave (
        output desc_valid_i, desc_target_i, desc_service_i, desc_task_i, desc_cons_i,
        output desc_len_i, pld_valid_i, pld_data_i, credit_i,
        input  desc_ready_o, pld_ready_o, tx_o, eop_o, data_o
    );
endinterface

// File: rtl/hermes_packet_builder.sv
// Hermes packet builder: serialises one descriptor plus payload words into
// target, size, service, task, consumer, [ts_lo, ts_hi], payload flits with eop on the last.
// Optional feature macro: HERMES_BUILDER_TIMESTAMP_EN (adds two timestamp flits after consumer).
module hermes_packet_builder #(
    parameter int unsigned FLIT_SIZE = 32,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hermes_builder_if.master    bus,
    input  logic [63:0]         tick_cntr_i,
    output logic                busy_o,
    output logic [31:0]         pkt_cnt_o
);

`ifdef HERMES_BUILDER_TIMESTAMP_EN
    localparam int unsigned TailFlits = 5;  // flits after size: service, task, cons, ts_lo, ts_hi
    typedef enum logic [3:0] {
        StIdle, StHeader, StSize, StService, StTask, StCons, StTsLo, StTsHi, StPayload
    } state_e;
    logic [63:0] ts_q;
`else
    localparam int unsigned TailFlits = 3;  // flits after size: service, task, cons
    typedef enum logic [2:0] {
        StIdle, StHeader, StSize, StService, StTask, StCons, StPayload
    } state_e;
    logic unused_tick;
    assign unused_tick = ^tick_cntr_i;
`endif

    state_e               state_q, state_d;
    logic [15:0]          target_q;
    logic [31:0]          service_q;
    logic [15:0]          task_q;
    logic [15:0]          cons_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     rem_q;
    logic [31:0]          pkt_cnt_q;

    logic                 tx;
    logic                 eop;
    logic [FLIT_SIZE-1:0] data;
    logic                 desc_ready;
    logic                 pld_ready;
    logic                 accept;
    logic                 xfer;

    assign accept = bus.desc_valid_i && desc_ready;
    assign xfer   = tx && bus.credit_i;

    // Next-state and link outputs; header flits come from the latched descriptor,
    // payload flits pass straight through from the payload stream.
    always_comb begin
        state_d    = state_q;
        tx         = 1'b0;
        eop        = 1'b0;
        data       = '0;
        desc_ready = 1'b0;
        pld_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                desc_ready = 1'b1;
                if (bus.desc_valid_i) state_d = StHeader;
            end
            StHeader: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(target_q);
                if (bus.credit_i) state_d = StSize;
            end
            StSize: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(len_q) + FLIT_SIZE'(TailFlits);
                if (bus.credit_i) state_d = StService;
            end
            StService: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(service_q);
                if (bus.credit_i) state_d = StTask;
            end
            StTask: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(task_q);
                if (bus.credit_i) state_d = StCons;
            end
`ifdef HERMES_BUILDER_TIMESTAMP_EN
            StCons: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(cons_q);
                if (bus.credit_i) state_d = StTsLo;
            end
            StTsLo: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(ts_q[31:0]);
                if (bus.credit_i) state_d = StTsHi;
            end
            StTsHi: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(ts_q[63:32]);
                eop  = (len_q == '0);
                if (bus.credit_i) state_d = (len_q == '0) ? StIdle : StPayload;
            end
`else
            StCons: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(cons_q);
                eop  = (len_q == '0);
                if (bus.credit_i) state_d = (len_q == '0) ? StIdle : StPayload;
            end
`endif
            StPayload: begin
                tx        = bus.pld_valid_i;
                data      = bus.pld_data_i;
                pld_ready = bus.credit_i;
                eop       = bus.pld_valid_i && (rem_q == LEN_W'(1));
                if (bus.pld_valid_i && bus.credit_i && (rem_q == LEN_W'(1))) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched descriptor, remaining payload count and packet counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            target_q  <= '0;
            service_q <= '0;
            task_q    <= '0;
            cons_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            pkt_cnt_q <= '0;
`ifdef HERMES_BUILDER_TIMESTAMP_EN
            ts_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                target_q  <= bus.desc_target_i;
                service_q <= bus.desc_service_i;
                task_q    <= bus.desc_task_i;
                cons_q    <= bus.desc_cons_i;
                len_q     <= bus.desc_len_i;
                rem_q     <= bus.desc_len_i;
`ifdef HERMES_BUILDER_TIMESTAMP_EN
                ts_q      <= tick_cntr_i;
`endif
            end
            if (xfer && (state_q == StPayload)) rem_q <= rem_q - LEN_W'(1);
            if (xfer && eop) pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign bus.tx_o         = tx;
    assign bus.eop_o        = eop;
    assign bus.data_o       = data;
    assign bus.desc_ready_o = desc_ready;
    assign bus.pld_ready_o  = pld_ready;
    assign busy_o           = (state_q != StIdle);
    assign pkt_cnt_o        = pkt_cnt_q;

endmodule
